// File: rtl/wide_uart_gen.sv
// wide_uart_gen: bridges DATA_WIDTH-bit AXI-Stream words to/from a UART line,
// one word = DATA_WIDTH/8 back-to-back 8N1 (or 8E1) byte frames.
// Ports: clk, rst (async, active high); s_axis_* TX word in; m_axis_* RX word out;
// RsRx serial in (async), RsTx serial out (idle high); err_frame/err_overrun/
// err_timeout/err_parity one-cycle error pulses.
// Optional: define WIDE_UART_GEN_PARITY_EN for an even-parity bit after the data.
module wide_uart_gen #(
    parameter int DATA_WIDTH      = 64,
    parameter int CLKS_PER_BIT    = 868,
    parameter bit MSB_FIRST       = 1'b0,
    parameter int RX_TIMEOUT_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  RsRx,
    output logic                  RsTx,
    output logic                  err_frame,
    output logic                  err_overrun,
    output logic                  err_timeout,
    output logic                  err_parity
);

`ifdef WIDE_UART_GEN_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int NBYTES   = DATA_WIDTH / 8;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int BW       = $clog2(NBYTES + 1);
    localparam int TO_LIMIT = RX_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(TO_LIMIT + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    // ---------------- transmitter ----------------
    state_t                tx_state, tx_next;
    logic [CW-1:0]         tx_cnt;
    logic [2:0]            tx_bit;
    logic [BW-1:0]         tx_byte;
    logic [DATA_WIDTH-1:0] tx_word;
    logic [7:0]            tx_cur;
    logic                  tx_tick;

    // The outgoing byte always sits at one end; the word shifts after each byte.
    assign tx_cur        = MSB_FIRST ? tx_word[DATA_WIDTH-1 -: 8] : tx_word[7:0];
    assign tx_tick       = (tx_cnt == BIT_LAST);
    assign s_axis_tready = (tx_state == S_IDLE);

    always_comb begin
        tx_next = tx_state;
        RsTx    = 1'b1;
        unique case (tx_state)
            S_IDLE: begin
                if (s_axis_tvalid) tx_next = S_START;
            end
            S_START: begin
                RsTx = 1'b0;
                if (tx_tick) tx_next = S_DATA;
            end
            S_DATA: begin
                RsTx = tx_cur[tx_bit];
                if (tx_tick && tx_bit == 3'd7)
                    tx_next = PAR_EN ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                RsTx = ^tx_cur;
                if (tx_tick) tx_next = S_STOP;
            end
            S_STOP: begin
                if (tx_tick)
                    tx_next = (tx_byte == BYTE_LAST) ? S_IDLE : S_START;
            end
            default: tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            tx_word  <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_state == S_IDLE) begin
                tx_cnt  <= '0;
                tx_bit  <= '0;
                tx_byte <= '0;
                if (s_axis_tvalid) tx_word <= s_axis_tdata;
            end else begin
                tx_cnt <= tx_tick ? '0 : tx_cnt + CW'(1);
                if (tx_tick && tx_state == S_DATA)
                    tx_bit <= tx_bit + 3'd1;
                if (tx_tick && tx_state == S_STOP) begin
                    tx_byte <= tx_byte + BW'(1);
                    tx_word <= MSB_FIRST ? (tx_word << 8) : (tx_word >> 8);
                end
            end
        end
    end

    // ---------------- receiver ----------------
    state_t                rx_state, rx_next;
    logic                  rx_s1, rx_s2, rx_d;
    logic [CW-1:0]         rx_cnt;
    logic [2:0]            rx_bit;
    logic [7:0]            rx_sh;
    logic                  rx_par;
    logic [BW-1:0]         rx_bytes;
    logic [DATA_WIDTH-1:0] rx_word, word_nxt;
    logic [TW-1:0]         to_cnt;
    logic                  rx_tick, half_tick, stop_smp;
    logic                  par_bad, byte_ok, word_done;

    assign rx_tick   = (rx_cnt == BIT_LAST);
    assign half_tick = (rx_state == S_START) && (rx_cnt == HALF_LAST);
    assign stop_smp  = (rx_state == S_STOP) && rx_tick;
    assign par_bad   = PAR_EN && (rx_par != ^rx_sh);
    assign byte_ok   = stop_smp && rx_s2 && !par_bad;
    assign word_done = byte_ok && (rx_bytes == BYTE_LAST);

    // First-received byte ends up at the low end (LSB order) or the high end.
    assign word_nxt = MSB_FIRST
        ? ((rx_word << 8) | DATA_WIDTH'(rx_sh))
        : ((rx_word >> 8) | (DATA_WIDTH'(rx_sh) << (DATA_WIDTH - 8)));

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            S_IDLE: begin
                if (rx_d && !rx_s2) rx_next = S_START;
            end
            S_START: begin
                // A high re-sample at mid-start is a glitch, not a frame.
                if (half_tick) rx_next = rx_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (rx_tick && rx_bit == 3'd7)
                    rx_next = PAR_EN ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (rx_tick) rx_next = S_STOP;
            end
            S_STOP: begin
                // Back to idle at mid-stop so the next start edge is caught.
                if (rx_tick) rx_next = S_IDLE;
            end
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            rx_d          <= 1'b1;
            rx_state      <= S_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_sh         <= '0;
            rx_par        <= 1'b0;
            rx_bytes      <= '0;
            rx_word       <= '0;
            to_cnt        <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            err_frame     <= 1'b0;
            err_overrun   <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            rx_s1       <= RsRx;
            rx_s2       <= rx_s1;
            rx_d        <= rx_s2;
            rx_state    <= rx_next;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;

            if (rx_state == S_IDLE || half_tick || rx_tick)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + CW'(1);

            if (rx_state == S_IDLE) begin
                rx_bit <= '0;
            end else if (rx_state == S_DATA && rx_tick) begin
                rx_sh  <= {rx_s2, rx_sh[7:1]};
                rx_bit <= rx_bit + 3'd1;
            end

            if (rx_state == S_PARITY && rx_tick)
                rx_par <= rx_s2;

            if (stop_smp) begin
                if (!rx_s2) begin
                    err_frame <= 1'b1;
                    rx_bytes  <= '0;
                end else if (par_bad) begin
                    rx_bytes <= '0;
                end else begin
                    rx_word  <= word_nxt;
                    rx_bytes <= word_done ? '0 : rx_bytes + BW'(1);
                end
            end

            // Inter-byte watchdog; only armed while a word is half-built.
            if (rx_state != S_IDLE || rx_next != S_IDLE || rx_bytes == '0) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                to_cnt      <= '0;
                rx_bytes    <= '0;
                err_timeout <= 1'b1;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end

            if (m_axis_tvalid && m_axis_tready)
                m_axis_tvalid <= 1'b0;
            if (word_done) begin
                if (!m_axis_tvalid || m_axis_tready) begin
                    m_axis_tdata  <= word_nxt;
                    m_axis_tvalid <= 1'b1;
                end else begin
                    err_overrun <= 1'b1;
                end
            end
        end
    end

`ifdef WIDE_UART_GEN_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_parity <= 1'b0;
        else
            err_parity <= stop_smp && rx_s2 && par_bad;
    end
`else
    assign err_parity = 1'b0;
`endif

endmodule

// File: doc/wide_uart_gen.md
Name: wide_uart_gen

Overview:
Parametrised wide-word UART bridge: packs/unpacks DATA_WIDTH-bit AXI-Stream words to/from a serial line as DATA_WIDTH/8 consecutive UART bytes.
Successor to the fixed 64-bit wide UART, adding:
- configurable width, bit time, byte order and RX inter-byte timeout;
- receive error reporting (framing, overrun, timeout, parity).
Sits between the host-side AXI-Stream fabric and the board RsTx/RsRx pins.

Parameters:
- DATA_WIDTH, 64: word width; multiple of 8, >= 8; NBYTES = DATA_WIDTH/8.
- CLKS_PER_BIT, 868: clk cycles per serial bit; >= 4.
- MSB_FIRST, 0: 0 sends byte [7:0] first; 1 sends byte [DATA_WIDTH-1:DATA_WIDTH-8] first. Applies to both TX and RX.
- RX_TIMEOUT_BITS, 32: idle bit-times allowed between bytes of a partially received word.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- s_axis_tdata  in  DATA_WIDTH  TX word
- s_axis_tvalid  in  1  TX word valid
- s_axis_tready  out  1  TX ready to accept a word
- m_axis_tdata  out  DATA_WIDTH  RX word
- m_axis_tvalid  out  1  RX word valid
- m_axis_tready  in  1  downstream ready
- RsRx  in  1  serial in; asynchronous to clk
- RsTx  out  1  serial out; idle high
- err_frame  out  1  one-cycle pulse: stop bit sampled low
- err_overrun  out  1  one-cycle pulse: completed RX word dropped
- err_timeout  out  1  one-cycle pulse: partial RX word discarded
- err_parity  out  1  one-cycle pulse: parity mismatch; always 0 without PARITY_EN

Behaviour:
- Reset values (async assert, all state cleared immediately): RsTx=1, s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, all err_*=0.
- Reset mid-frame aborts both TX and RX; no partial word survives.
- TX handshake:
  - Word captured on s_axis_tvalid && s_axis_tready.
  - s_axis_tready is 0 from the next cycle until the final stop bit of byte NBYTES-1 completes; it returns to 1 the following cycle.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> [PARITY] -> STOP -> START of next byte, or IDLE after the last byte.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - No gap between bytes of one word.
  - RsTx goes low the cycle after capture.
- RX input path:
  - RsRx passes through a 2-flop synchroniser.
  - Falling edge in IDLE -> START: wait CLKS_PER_BIT/2 cycles, re-sample.
  - If the re-sample is high, it is a false start: return to IDLE, no error.
  - Otherwise DATA: sample each bit at mid-bit, every CLKS_PER_BIT cycles.
  - Then [PARITY], then STOP at mid-bit.
- RX byte assembly:
  - Good stop bit: byte placed per MSB_FIRST; byte counter increments.
  - On byte NBYTES: word loads m_axis_tdata, m_axis_tvalid=1 the next cycle, byte counter clears.
  - The FSM returns to IDLE at mid-stop, so back-to-back frames are received.
- RX output:
  - m_axis_tvalid holds, with stable data, until m_axis_tvalid && m_axis_tready.
  - Handshake and new-word completion in the same cycle: old word leaves, new word loads, tvalid stays 1.
  - New-word completion with tvalid=1 and tready=0: new word dropped, err_overrun pulses, held word unchanged.
- Framing error: stop bit low -> err_frame pulse; byte counter and partial word discarded; RX returns to IDLE.
- Timeout:
  - The counter runs while RX is IDLE and byte counter > 0.
  - Reaching RX_TIMEOUT_BITS*CLKS_PER_BIT: byte counter cleared, err_timeout pulses.
  - A start edge clears the counter.
- TX and RX are fully independent; simultaneous operation is permitted.
- Loopback latency: about NBYTES*(10 or 11)*CLKS_PER_BIT cycles from capture to m_axis_tvalid.

Optional Feature:
- Macro: WIDE_UART_GEN_PARITY_EN.
- Defined:
  - TX inserts an even-parity bit after the 8 data bits (11-bit frame).
  - RX checks it. On mismatch: err_parity pulses at the stop-bit sample, the whole partial word is discarded, byte counter clears.
- Undefined: 8N1 framing (10-bit frame); err_parity tied 0.

Test Plan:
1. DATA_WIDTH=64, CLKS_PER_BIT=8, loopback RsRx=RsTx, send 64'hfeedfacedeadbeef -> m_axis_tdata=64'hfeedfacedeadbeef; s_axis_tready low exactly 640 cycles (8 bytes x 10 bits x 8); no err_* pulse.
2. DATA_WIDTH=32, MSB_FIRST=1, loopback, send 32'h12345678 -> first byte on RsTx is 0x12; received word is 32'h12345678.
3. Loopback, m_axis_tready=0, send 64'h1111111111111111 then 64'h2222222222222222 -> err_overrun pulses once; m_axis_tdata stays 64'h1111111111111111. Raise tready -> one handshake only.
4. Bench drives RsRx with byte 0xA5 whose stop bit is 0 -> err_frame pulses. Next full 8-byte word 0x0123456789ABCDEF is received intact.
5. Drive 3 valid bytes, then hold RsRx high for 32x8 cycles -> err_timeout pulses, no m_axis_tvalid. A following 8-byte word is received correctly.
6. With WIDE_UART_GEN_PARITY_EN, CLKS_PER_BIT=8: loopback 64'hdeadbeefcafef00d passes with 704-cycle tready-low. Bench-driven word with byte 2 parity flipped -> err_parity pulse, word dropped.
